// File: rtl/alu_pkg.sv
// Shared op codes and occupancy states for the ALU execute stage.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } occ_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus carry/overflow/illegal/zero/negative flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             illegal_op,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf_raw;

  // One shared adder; SUB and SLT both evaluate A + ~B + 1.
  always_comb begin
    b_eff = SrcB;
    cin   = 1'b0;
    if (ALUControl == ALU_SUB || ALUControl == ALU_SLT) begin
      b_eff = ~SrcB;
      cin   = 1'b1;
    end
    sum     = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    ovf_raw = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != SrcA[WIDTH-1]);
  end

  always_comb begin
    result     = '0;
    carry      = 1'b0;
    overflow   = 1'b0;
    illegal_op = 1'b0;
    case (ALUControl)
      ALU_ADD, ALU_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = ovf_raw;
      end
      ALU_AND: result = SrcA & SrcB;
      ALU_OR:  result = SrcA | SrcB;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
      default: illegal_op = 1'b1;
    endcase
    zero     = (result == '0);
    negative = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with valid/ready handshakes and a 2-entry skid buffer.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             IllegalOp
);

  // Flag bundle order: {illegal, overflow, carry, negative, zero}
  logic [WIDTH-1:0] core_result;
  logic [4:0]       core_flags;
  logic             core_carry, core_ovf, core_ill, core_zero, core_neg;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .result    (core_result),
    .carry     (core_carry),
    .overflow  (core_ovf),
    .illegal_op(core_ill),
    .zero      (core_zero),
    .negative  (core_neg)
  );

  assign core_flags = {core_ill, core_ovf, core_carry, core_neg, core_zero};

  occ_state_e       state_q, state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_result_q, skid_result_q;
  logic [4:0]       main_flags_q, skid_flags_q;
  logic             in_fire;
  logic             load_main, main_from_skid, load_skid;

  assign in_fire = in_valid & in_ready_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_ready) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          state_d        = ST_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // in_ready comes from a flop fed by next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      in_ready_q    <= 1'b1;
      main_result_q <= '0;
      main_flags_q  <= '0;
      skid_result_q <= '0;
      skid_flags_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (load_main) begin
        main_result_q <= core_result;
        main_flags_q  <= core_flags;
      end else if (main_from_skid) begin
        main_result_q <= skid_result_q;
        main_flags_q  <= skid_flags_q;
      end
      if (load_skid) begin
        skid_result_q <= core_result;
        skid_flags_q  <= core_flags;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign ALUResult = main_result_q;
  assign Zero      = main_flags_q[0];
  assign Negative  = main_flags_q[1];
  assign Carry     = main_flags_q[2];
  assign Overflow  = main_flags_q[3];
  assign IllegalOp = main_flags_q[4];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero, Negative, Carry, Overflow, IllegalOp;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(
    .WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUControl(ALUControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .Negative  (Negative),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .IllegalOp (IllegalOp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
  endtask

  // Flags packed {illegal, overflow, carry, negative, zero}.
  task automatic check_out(input string tag, input logic [31:0] res, input logic [4:0] flags);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".result"}, ALUResult, res);
    check({tag, ".flags"}, {27'b0, IllegalOp, Overflow, Carry, Negative, Zero},
          {27'b0, flags});
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ALUControl = 3'b000;
    SrcA       = '0;
    SrcB       = '0;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.result", ALUResult, 32'd0);
    check("rst.flags", {27'b0, IllegalOp, Overflow, Carry, Negative, Zero}, 32'd0);
    check("rst.in_ready", {31'b0, in_ready}, 32'd1);

    // ADD with signed overflow
    out_ready = 1'b1;
    drive(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    step();
    in_valid = 1'b0;
    check_out("add_ovf", 32'h8000_0000, 5'b01010);
    step();
    check("add_ovf.drained", {31'b0, out_valid}, 32'd0);

    // SUB then SLT back to back
    drive(3'b001, 32'd5, 32'd5);
    step();
    drive(3'b101, 32'hFFFF_FFFF, 32'd1);
    check_out("sub_eq", 32'd0, 5'b00101);
    step();
    in_valid = 1'b0;
    check_out("slt_neg", 32'd1, 5'b00000);
    step();

    // ADD with unsigned carry-out wrapping to zero
    drive(3'b000, 32'hFFFF_FFFF, 32'd1);
    step();
    drive(3'b001, 32'd3, 32'd5);
    check_out("add_carry", 32'd0, 5'b00101);
    step();
    in_valid = 1'b0;
    check_out("sub_borrow", 32'hFFFF_FFFE, 5'b00010);
    step();

    // Back-pressure: A, B buffered, C held off
    out_ready = 1'b0;
    drive(3'b000, 32'd1, 32'd1);
    step();
    check("bp.in_ready_one", {31'b0, in_ready}, 32'd1);
    drive(3'b000, 32'd2, 32'd2);
    step();
    drive(3'b000, 32'd3, 32'd3);
    check("bp.in_ready_two", {31'b0, in_ready}, 32'd0);
    check_out("bp.a_head", 32'd2, 5'b00000);
    step();
    check("bp.held_ready", {31'b0, in_ready}, 32'd0);
    check_out("bp.a_stable", 32'd2, 5'b00000);
    out_ready = 1'b1;
    step();
    check_out("bp.b", 32'd4, 5'b00000);
    check("bp.ready_again", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check_out("bp.c", 32'd6, 5'b00000);
    step();
    check("bp.drained", {31'b0, out_valid}, 32'd0);

    // Illegal code, held under back-pressure
    out_ready = 1'b0;
    drive(3'b111, 32'h0000_FFFF, 32'd1);
    step();
    in_valid = 1'b0;
    check_out("illegal", 32'd0, 5'b10001);
    step();
    check_out("illegal.stable", 32'd0, 5'b10001);
    out_ready = 1'b1;
    step();

    // AND then OR
    drive(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step();
    drive(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    check_out("and", 32'hF000_F000, 5'b00010);
    step();
    in_valid = 1'b0;
    check_out("or", 32'hFFF0_FFF0, 5'b00010);
    step();

    // Reset while two bundles are buffered
    out_ready = 1'b0;
    drive(3'b001, 32'd3, 32'd5);
    step();
    drive(3'b000, 32'd7, 32'd7);
    step();
    check("rst2.pre_full", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    drive(3'b000, 32'd9, 32'd9);
    step();
    check("rst2.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst2.result", ALUResult, 32'd0);
    check("rst2.flags", {27'b0, IllegalOp, Overflow, Carry, Negative, Zero}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("rst2.in_ready", {31'b0, in_ready}, 32'd1);
    check("rst2.ignored", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    drive(3'b000, 32'd2, 32'd3);
    step();
    in_valid = 1'b0;
    check_out("rst2.add", 32'd5, 5'b00000);
    step();
    check("rst2.drained", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the ALU control decoder; consumes its 3-bit ALUControl plus SrcA/SrcB and produces a registered ALUResult and flags.
- Valid/ready handshake on both sides; 2-entry skid buffer so back-pressure from the consumer never drops or reorders an operation.
- Pure combinational compute sits in a sub-core; this block owns registering, flow control and flag generation.

Parameters:
- WIDTH, 32, operand/result width in bits (must be >= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents a valid operation
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready
- ALUControl  input  3  operation code from the ALU decoder
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B
- out_valid  output  1  ALUResult/flags valid
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready
- ALUResult  output  WIDTH  registered result
- Zero  output  1  ALUResult == 0
- Negative  output  1  ALUResult[WIDTH-1]
- Carry  output  1  carry-out of add/sub adder, else 0
- Overflow  output  1  signed overflow of add/sub, else 0
- IllegalOp  output  1  ALUControl was an unsupported code

Behaviour:
- Op codes: 000 ADD A+B; 001 SUB A-B (A+~B+1); 010 AND; 011 OR; 101 SLT, result = {0..0, N^V of A-B} (signed less-than). Codes 100/110/111: result 0, IllegalOp=1, other flags computed from result 0 (Zero=1).
- All arithmetic is modulo 2^WIDTH. Carry = adder carry-out for ADD and SUB (SUB: 1 means A >= B unsigned); 0 for AND/OR/SLT/illegal. Overflow = (A[msb]==B'[msb]) & (R[msb]!=A[msb]) with B'=B for ADD, ~B for SUB; 0 otherwise.
- Flags are computed at input, registered with the result as one bundle; bundles never mix.
- Occupancy FSM: EMPTY, ONE (main reg full), TWO (main + skid full).
  - EMPTY: in fire -> ONE (bundle into main).
  - ONE: in fire & out fire -> ONE (main reloaded); in fire & !out_ready -> TWO (bundle into skid); !in fire & out fire -> EMPTY; else hold.
  - TWO: in_ready=0; out fire -> ONE (skid moves to main); else hold.
- in_ready = (state != TWO), driven from a register (no combinational in_ready<-out_ready path). out_valid = (state != EMPTY).
- Latency: 1 cycle from input fire to out_valid when empty. Throughput: 1 op/cycle with out_ready held high.
- Outputs stable while out_valid & !out_ready (no change until fire).
- Inputs ignored when in_ready=0 or in_valid=0; ALUControl/SrcA/SrcB sampled only at fire.
- Reset (including mid-operation): state EMPTY, both buffered bundles discarded; out_valid=0, ALUResult=0, all flags 0, IllegalOp=0; in_ready=1 from first cycle after rst deasserts. in_valid during rst is ignored.

Decomposition:
- Package alu_pkg: localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101; FSM state encodings ST_EMPTY/ST_ONE/ST_TWO (2 bits).
- One sub-module: alu_core (combinational; ALUControl, SrcA, SrcB -> result, Carry, Overflow, IllegalOp). Zero/Negative derived from the result in the core as well.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> next cycle out_valid=1, ALUResult=0x80000000, Negative=1, Overflow=1, Carry=0, Zero=0.
- SUB 5 - 5 then SLT 0xFFFFFFFF vs 1, back-to-back -> results 0 (Zero=1, Carry=1) then 1 (SLT true, Zero=0), one per cycle.
- Back-pressure: out_ready=0, issue ops A,B,C on consecutive cycles -> A, B accepted, in_ready=0 while C is held; raising out_ready delivers A, B, C in order, none lost or duplicated.
- Illegal ALUControl=3'b111, SrcA=0xFFFF, SrcB=0x1 -> ALUResult=0, IllegalOp=1, Zero=1, Carry=0, Overflow=0.
- AND 0xF0F0F0F0 & 0xFF00FF00 = 0xF000F000; OR same operands = 0xFFF0FFF0; both with Carry=0, Overflow=0.
- Reset mid-operation in state TWO -> next cycle out_valid=0, ALUResult=0, flags 0, in_ready=1; a new ADD 2+3 afterwards returns 5.
